wr_sched_2r3w: RTL
==================

WR_SCHED_2R3W -- requirements
Module: wr_sched_2r3w

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width of each requester and of each physical port.
REQ-002 SHALL have parameter BITADDR, default 10: address width.
REQ-003 SHALL have parameter NUMADDR, default 1024: number of valid addresses.
REQ-004 SHALL have parameter NUMWREQ, default 4: number of write requesters; legal range 3..8.
REQ-005 SHALL have parameter SRAM_DELAY, default 1: physical read latency in cycles; legal range 0..3.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have ports wr_vld, input, NUMWREQ bits; wr_rdy, output, NUMWREQ bits: per-requester write handshake.
REQ-009 SHALL have ports wr_adr (NUMWREQ*BITADDR), din (NUMWREQ*WIDTH), bw (NUMWREQ*WIDTH), all inputs: packed write address, data and bit-enable per requester.
REQ-010 SHALL have ports read, input, 2 bits; rd_adr, input, 2*BITADDR bits: the two logical read requests.
REQ-011 SHALL have ports rd_vld, output, 2 bits; rd_dout, output, 2*WIDTH bits: read responses.
REQ-012 SHALL have outputs t1_writeA/B/C (1 bit each), t1_addrA/B/C (BITADDR), t1_dinA/B/C (WIDTH), t1_bwA/B/C (WIDTH): the three physical write ports.
REQ-013 SHALL have outputs t1_readD/E (1 bit each) and t1_addrD/E (BITADDR), and inputs t1_doutD/E (WIDTH): the two physical read ports.
REQ-014 SHALL have output wr_err, 1 bit: pulses when an accepted write was out of range.

Function
REQ-015 SHALL hold a round-robin pointer ptr of width ceil(log2(NUMWREQ)).
REQ-016 Each cycle, SHALL scan requesters ptr, ptr+1, ... modulo NUMWREQ and grant at most 3 with wr_vld set, in scan order.
REQ-017 SHALL drive wr_rdy[i] combinationally, equal to the grant for requester i; wr_rdy SHALL never assert without the matching wr_vld.
REQ-018 SHALL assign grants in scan order to port A, then B, then C; unused ports SHALL drive t1_writeX=0.
REQ-019 SHALL register all physical port outputs: a write accepted in cycle N appears on its t1_writeX in cycle N+1, carrying the unmodified address, din and bw.
REQ-020 SHALL set ptr to (last granted index + 1) mod NUMWREQ after a cycle with any grant, and leave ptr unchanged after a cycle with no grant.
REQ-021 An accepted write with wr_adr >= NUMADDR SHALL be consumed (wr_rdy=1), SHALL not drive any port, and SHALL cause wr_err=1 in cycle N+1 only.
REQ-022 Reads: read[k] and rd_adr in cycle N SHALL produce t1_readD (k=0) or t1_readE (k=1) in cycle N+1; reads SHALL never stall.
REQ-023 A read presented in cycle N SHALL produce rd_vld[k]=1 in cycle N+1+SRAM_DELAY, with rd_dout[k] equal to t1_doutD/E sampled in that cycle.
REQ-024 rd_vld SHALL be produced by a shift register of depth 1+SRAM_DELAY.
REQ-025 An out-of-range read SHALL be forwarded without modification; the physical memory handles it.
REQ-026 Simultaneous reads and writes to the same address SHALL be issued unchanged; read-during-write semantics belong to the physical memory.

Reset
REQ-027 While rst=0: ptr=0; t1_writeA/B/C=0; t1_readD/E=0; rd_vld=0; wr_err=0; wr_rdy=0.
REQ-028 While rst=0, the rd_vld pipeline SHALL be cleared, so reads in flight at reset are dropped.
REQ-029 Address, data and bw output registers need no reset value.
REQ-030 The first grant SHALL occur in the first rising edge after rst deasserts.

Configuration
REQ-031 With macro WR_CONFLICT_EN defined, a scanned request whose address equals that of an already-granted request in the same cycle SHALL not be granted.
REQ-032 With WR_CONFLICT_EN defined, scanning SHALL continue past a denied request, and that request SHALL not count toward the 3-grant limit.
REQ-033 Without WR_CONFLICT_EN, conflicting writes SHALL all be granted and issued on distinct ports; port C overrides B, which overrides A, in the memory.

Verification
REQ-034 After reset, wr_vld=4'b1111, ptr=0 -> grants 0,1,2 on A,B,C at N+1; next cycle grants 3,0,1; ptr sequence 0, 3, 2.
REQ-035 wr_vld=4'b0100 only -> grant 2 on port A; B and C idle; ptr=3.
REQ-036 With WR_CONFLICT_EN, requesters 0 and 1 both at address 5, ptr=0 -> only 0 granted that cycle; 1 granted the next cycle; without the macro, both granted on A and B.
REQ-037 Write with wr_adr=1024 while NUMADDR=1024 -> wr_rdy=1, no t1_write, wr_err pulse for exactly 1 cycle.
REQ-038 SRAM_DELAY=2, read=2'b11 in cycle 10 -> t1_readD/E=1 in cycle 11; rd_vld=2'b11 in cycle 13 with t1_doutD/E values.
REQ-039 Assert rst low mid-burst with reads in flight -> all outputs 0 immediately, with no clock edge needed; no rd_vld appears after release.

Source files
------------

// File: rtl/wr_sched_2r3w_if.sv
// wr_sched_2r3w_if: bundles the requester-side handshake, the logical read
// ports and the physical 3W/2R memory ports of wr_sched_2r3w.
//   master: requesters plus physical memory (drives requests and t1_dout*)
//   slave : the scheduler (drives wr_rdy, rd_vld/rd_dout, wr_err, t1_* commands)
// Parameters WIDTH/BITADDR/NUMWREQ must match those of the scheduler.
interface wr_sched_2r3w_if #(
    parameter int WIDTH   = 16,
    parameter int BITADDR = 10,
    parameter int NUMWREQ = 4
) ();
    // Write requesters (packed, requester i at slice i)
    logic [NUMWREQ-1:0]         wr_vld;
    logic [NUMWREQ-1:0]         wr_rdy;
    logic [NUMWREQ*BITADDR-1:0] wr_adr;
    logic [NUMWREQ*WIDTH-1:0]   din;
    logic [NUMWREQ*WIDTH-1:0]   bw;
    logic                       wr_err;
    // Logical reads
    logic [1:0]                 read;
    logic [2*BITADDR-1:0]       rd_adr;
    logic [1:0]                 rd_vld;
    logic [2*WIDTH-1:0]         rd_dout;
    // Physical write ports A/B/C
    logic                       t1_writeA, t1_writeB, t1_writeC;
    logic [BITADDR-1:0]         t1_addrA, t1_addrB, t1_addrC;
    logic [WIDTH-1:0]           t1_dinA, t1_dinB, t1_dinC;
    logic [WIDTH-1:0]           t1_bwA, t1_bwB, t1_bwC;
    // Physical read ports D/E
    logic                       t1_readD, t1_readE;
    logic [BITADDR-1:0]         t1_addrD, t1_addrE;
    logic [WIDTH-1:0]           t1_doutD, t1_doutE;

    modport master (
        output wr_vld, wr_adr, din, bw, read, rd_adr, t1_doutD, t1_doutE,
        input  wr_rdy, wr_err, rd_vld, rd_dout,
        input  t1_writeA, t1_writeB, t1_writeC, t1_addrA, t1_addrB, t1_addrC,
        input  t1_dinA, t1_dinB, t1_dinC, t1_bwA, t1_bwB, t1_bwC,
        input  t1_readD, t1_readE, t1_addrD, t1_addrE
    );

    modport slave (
        input  wr_vld, wr_adr, din, bw, read, rd_adr, t1_doutD, t1_doutE,
        output wr_rdy, wr_err, rd_vld, rd_dout,
        output t1_writeA, t1_writeB, t1_writeC, t1_addrA, t1_addrB, t1_addrC,
        output t1_dinA, t1_dinB, t1_dinC, t1_bwA, t1_bwB, t1_bwC,
        output t1_readD, t1_readE, t1_addrD, t1_addrE
    );
endinterface

// File: rtl/wr_sched_2r3w.sv
// wr_sched_2r3w: maps NUMWREQ write requesters onto three physical write ports
// (A/B/C) with a round-robin scan, and forwards two logical reads to physical
// read ports D/E with a valid pipeline matching the memory latency.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - wr_sched_2r3w_if.slave: requester handshake, reads, physical ports
// Optional feature: define WR_CONFLICT_EN to deny a request whose address
// matches one already granted in the same cycle (it does not use a grant slot).
module wr_sched_2r3w #(
    parameter int WIDTH      = 16,
    parameter int BITADDR    = 10,
    parameter int NUMADDR    = 1024,
    parameter int NUMWREQ    = 4,
    parameter int SRAM_DELAY = 1
) (
    input logic             clk,
    input logic             rst,
    wr_sched_2r3w_if.slave  bus
);
    localparam int PW = $clog2(NUMWREQ);

    logic [PW-1:0]      r_ptr;
    logic [2:0]         r_write;
    logic [BITADDR-1:0] r_addr [3];
    logic [WIDTH-1:0]   r_din [3];
    logic [WIDTH-1:0]   r_bw [3];
    logic               r_err;
    logic [1:0]         r_read;
    logic [BITADDR-1:0] r_raddr [2];
    logic [1:0]         r_vld_pipe [SRAM_DELAY+1];

    logic [BITADDR-1:0] w_adr_arr [NUMWREQ];
    logic [WIDTH-1:0]   w_din_arr [NUMWREQ];
    logic [WIDTH-1:0]   w_bw_arr [NUMWREQ];

    logic [NUMWREQ-1:0] w_grant;
    logic [1:0]         w_cnt;
    logic [2:0]         w_slot_used;
    logic [2:0]         w_slot_inrng;
    logic [PW-1:0]      w_slot_idx [3];
    logic [BITADDR-1:0] w_slot_adr [3];
    logic [PW-1:0]      w_ptr_nxt;
    logic [PW:0]        w_sum;
    logic [PW-1:0]      w_idx;
    logic [BITADDR-1:0] w_adr;
    logic               w_dup;

    // Unpack requester buses with constant slices.
    for (genvar i = 0; i < NUMWREQ; i++) begin : g_unpack
        assign w_adr_arr[i] = bus.wr_adr[i*BITADDR +: BITADDR];
        assign w_din_arr[i] = bus.din[i*WIDTH +: WIDTH];
        assign w_bw_arr[i]  = bus.bw[i*WIDTH +: WIDTH];
    end

    // Round-robin scan from r_ptr; the k-th grant in scan order takes port k.
    always_comb begin
        w_grant      = '0;
        w_cnt        = 2'd0;
        w_slot_used  = '0;
        w_slot_inrng = '0;
        w_ptr_nxt    = r_ptr;
        w_sum        = '0;
        w_idx        = '0;
        w_adr        = '0;
        w_dup        = 1'b0;
        for (int s = 0; s < 3; s++) begin
            w_slot_idx[s] = '0;
            w_slot_adr[s] = '0;
        end
        for (int j = 0; j < NUMWREQ; j++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(j);
            if (w_sum >= (PW+1)'(NUMWREQ)) begin
                w_sum = w_sum - (PW+1)'(NUMWREQ);
            end
            w_idx = w_sum[PW-1:0];
            w_adr = w_adr_arr[w_idx];
            w_dup = 1'b0;
`ifdef WR_CONFLICT_EN
            for (int s = 0; s < 3; s++) begin
                if (w_slot_used[s] && (w_slot_adr[s] == w_adr)) begin
                    w_dup = 1'b1;
                end
            end
`endif
            if (bus.wr_vld[w_idx] && !w_dup && (w_cnt != 2'd3)) begin
                w_grant[w_idx]       = 1'b1;
                w_slot_used[w_cnt]   = 1'b1;
                w_slot_idx[w_cnt]    = w_idx;
                w_slot_adr[w_cnt]    = w_adr;
                // Out-of-range writes are consumed but never reach a port.
                w_slot_inrng[w_cnt]  = (32'(w_adr) < 32'(NUMADDR));
                w_ptr_nxt            = (w_idx == PW'(NUMWREQ - 1)) ? '0 : w_idx + 1'b1;
                w_cnt                = w_cnt + 2'd1;
            end
        end
    end

    assign bus.wr_rdy = rst ? w_grant : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr   <= '0;
            r_write <= '0;
            r_err   <= 1'b0;
            r_read  <= '0;
            for (int i = 0; i <= SRAM_DELAY; i++) begin
                r_vld_pipe[i] <= '0;
            end
        end else begin
            if (|w_grant) begin
                r_ptr <= w_ptr_nxt;
            end
            r_write       <= w_slot_used & w_slot_inrng;
            r_err         <= |(w_slot_used & ~w_slot_inrng);
            r_read        <= bus.read;
            r_vld_pipe[0] <= bus.read;
            for (int i = 1; i <= SRAM_DELAY; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
            end
        end
    end

    // Payload registers carry no reset; they are qualified by r_write/r_read.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 3; s++) begin
            r_addr[s] <= w_slot_adr[s];
            r_din[s]  <= w_din_arr[w_slot_idx[s]];
            r_bw[s]   <= w_bw_arr[w_slot_idx[s]];
        end
        r_raddr[0] <= bus.rd_adr[0 +: BITADDR];
        r_raddr[1] <= bus.rd_adr[BITADDR +: BITADDR];
    end

    assign bus.t1_writeA = r_write[0];
    assign bus.t1_writeB = r_write[1];
    assign bus.t1_writeC = r_write[2];
    assign bus.t1_addrA  = r_addr[0];
    assign bus.t1_addrB  = r_addr[1];
    assign bus.t1_addrC  = r_addr[2];
    assign bus.t1_dinA   = r_din[0];
    assign bus.t1_dinB   = r_din[1];
    assign bus.t1_dinC   = r_din[2];
    assign bus.t1_bwA    = r_bw[0];
    assign bus.t1_bwB    = r_bw[1];
    assign bus.t1_bwC    = r_bw[2];
    assign bus.wr_err    = r_err;

    assign bus.t1_readD  = r_read[0];
    assign bus.t1_readE  = r_read[1];
    assign bus.t1_addrD  = r_raddr[0];
    assign bus.t1_addrE  = r_raddr[1];

    // Read data is the memory output in the cycle the delayed valid lands.
    assign bus.rd_vld    = r_vld_pipe[SRAM_DELAY];
    assign bus.rd_dout   = {bus.t1_doutE, bus.t1_doutD};
endmodule
